// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU definitions for the hazard controller: register-number width
// and the encodings of the operand forward-select multiplexer.
package pipe_hazard_ctrl_pkg;

    localparam int RN_W_DEF = 5;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EX_ALU = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD = 2'b11;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel_unit.sv
// Maps one ID source register against EX/MEM destination state to a
// 2-bit forward select; the EX match wins over MEM, and r0 never forwards.
module fwd_sel_unit
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RN_W = RN_W_DEF
) (
    input  logic [RN_W-1:0] src,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic [RN_W-1:0] ern,
    input  logic            mwreg,
    input  logic            mm2reg,
    input  logic [RN_W-1:0] mrn,
    output logic [1:0]      sel
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = ewreg & (ern != '0) & (ern == src);
    assign mem_hit = mwreg & (mrn != '0) & (mrn == src);

    // A load still in EX has no data yet; that case is covered by the stall.
    always_comb begin
        sel = FWD_RF;
        if (ex_hit && !em2reg)
            sel = FWD_EX_ALU;
        else if (mem_hit && !mm2reg)
            sel = FWD_MEM_ALU;
        else if (mem_hit && mm2reg)
            sel = FWD_MEM_LD;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM destination state, produces
// operand forward selects, the load-use stall, and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RN_W  = RN_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             id_valid,
    input  logic [RN_W-1:0]  id_rs,
    input  logic [RN_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [RN_W-1:0]  id_rn,
    input  logic             flush_e,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic            ewreg, em2reg;
    logic [RN_W-1:0] ern;
    logic            mwreg, mm2reg;
    logic [RN_W-1:0] mrn;

    logic rs_dep, rt_dep;

    assign rs_dep = id_use_rs & (ern == id_rs);
    assign rt_dep = id_use_rt & (ern == id_rt);
    assign stall  = id_valid & ewreg & em2reg & (ern != '0) & (rs_dep | rt_dep);

    // The bubble injected on stall clears em2reg, so a stall never repeats.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            ewreg     <= 1'b0;
            em2reg    <= 1'b0;
            ern       <= '0;
            mwreg     <= 1'b0;
            mm2reg    <= 1'b0;
            mrn       <= '0;
            stall_cnt <= '0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mrn    <= ern;
            if (flush_e || stall) begin
                ewreg  <= 1'b0;
                em2reg <= 1'b0;
                ern    <= '0;
            end else begin
                ewreg  <= id_wreg & id_valid;
                em2reg <= id_m2reg & id_valid;
                ern    <= id_rn;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    fwd_sel_unit #(.RN_W(RN_W)) u_fwd_a (
        .src    (id_rs),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .ern    (ern),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .mrn    (mrn),
        .sel    (fwda)
    );

    fwd_sel_unit #(.RN_W(RN_W)) u_fwd_b (
        .src    (id_rt),
        .ewreg  (ewreg),
        .em2reg (em2reg),
        .ern    (ern),
        .mwreg  (mwreg),
        .mm2reg (mm2reg),
        .mrn    (mrn),
        .sel    (fwdb)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; stall counter narrowed to 2 bits so
// saturation is reachable in a handful of load-use pairs.
module tb_pipe_hazard_ctrl;

    localparam int RN_W  = 5;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             clrn;
    logic             id_valid;
    logic [RN_W-1:0]  id_rs, id_rt, id_rn;
    logic             id_use_rs, id_use_rt, id_wreg, id_m2reg;
    logic             flush_e;
    logic [1:0]       fwda, fwdb;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RN_W(RN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wreg   (id_wreg),
        .id_m2reg  (id_m2reg),
        .id_rn     (id_rn),
        .flush_e   (flush_e),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic w,
                          input logic m, input logic [4:0] rn);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = w; id_m2reg = m; id_rn = rn;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b0;
        flush_e = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_fwda", fwda, 0);
        chk("rst_fwdb", fwdb, 0);
        chk("rst_cnt", stall_cnt, 0);
        clrn = 1'b1;

        // ALU dependence: add r3, then two consumers of r3
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd3);
        tick();
        set_id(1, 5'd3, 5'd0, 1, 0, 0, 0, 5'd0);
        chk("alu_ex_fwda", fwda, 2'b01);
        chk("alu_ex_stall", stall, 0);
        tick();
        set_id(1, 5'd3, 5'd0, 1, 0, 0, 0, 5'd0);
        chk("alu_mem_fwda", fwda, 2'b10);
        idle(); tick(); tick();

        // Load-use on rt
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd5);
        tick();
        set_id(1, 5'd1, 5'd5, 1, 1, 0, 0, 5'd0);
        chk("ld_stall", stall, 1);
        chk("ld_cnt0", stall_cnt, 0);
        chk("ld_fwdb_ex", fwdb, 2'b00);
        tick();
        chk("ld_stall_clr", stall, 0);
        chk("ld_cnt1", stall_cnt, 1);
        chk("ld_fwdb_mem", fwdb, 2'b11);
        idle(); tick(); tick();

        // Load followed by a non-reading use of the same register number
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd6);
        tick();
        set_id(1, 5'd0, 5'd6, 0, 0, 0, 0, 5'd0);
        chk("nouse_stall", stall, 0);
        tick();
        chk("nouse_fwdb", fwdb, 2'b11);
        idle(); tick(); tick();

        // r0 never forwards or stalls
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd0);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0);
        chk("r0_alu_fwda", fwda, 2'b00);
        tick();
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd0);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0);
        chk("r0_ld_stall", stall, 0);
        chk("r0_ld_fwdb", fwdb, 2'b00);
        chk("r0_cnt", stall_cnt, 1);
        idle(); tick(); tick();

        // EX beats MEM when both write r7
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd7);
        tick();
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 0, 5'd7);
        tick();
        set_id(1, 5'd7, 5'd7, 1, 1, 0, 0, 5'd0);
        chk("prio_fwda", fwda, 2'b01);
        chk("prio_fwdb", fwdb, 2'b01);
        tick();
        chk("prio_mem_fwdb", fwdb, 2'b10);
        idle(); tick(); tick();

        // Flush squashes a load entering EX
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd4);
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        set_id(1, 5'd4, 5'd0, 1, 0, 0, 0, 5'd0);
        chk("flush_stall", stall, 0);
        chk("flush_fwda", fwda, 2'b00);
        tick();
        chk("flush_mem_fwda", fwda, 2'b00);
        idle(); tick();

        // Reset in the middle of a load-use stall
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd4);
        tick();
        set_id(1, 5'd4, 5'd0, 1, 0, 0, 0, 5'd0);
        chk("rst_mid_stall_pre", stall, 1);
        clrn = 1'b0;
        tick();
        chk("rst_mid_cnt", stall_cnt, 0);
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_fwda", fwda, 0);
        chk("rst_mid_fwdb", fwdb, 0);
        clrn = 1'b1;
        idle(); tick();

        // Saturation of the 2-bit counter over four load-use pairs
        for (int i = 0; i < 4; i++) begin
            set_id(1, 5'd1, 5'd2, 1, 1, 1, 1, 5'd9);
            tick();
            set_id(1, 5'd1, 5'd9, 1, 1, 0, 0, 5'd0);
            chk($sformatf("sat_stall%0d", i), stall, 1);
            tick();
            chk($sformatf("sat_cnt%0d", i), stall_cnt, (i < 3) ? i + 1 : 3);
            idle(); tick();
        end
        chk("sat_hold", stall_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
